seq_divider: RTL
================

// Module: seq_divider
// PURPOSE
//  Iterative unsigned restoring divider. It performs one trial subtraction per clock and is the
//  sequential counterpart to the lab's single-cycle add/subtract datapath.
//  It accepts an operand pair on a start pulse and returns quotient and remainder with a done strobe.
//  It sits between the operand registers and the result display/readout logic.
// PARAMETERS
//  WIDTH   8   operand, quotient and remainder width in bits (unsigned); must be >= 2
// PORTS
//  clk          in   1      single clock; all state updates on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  start        in   1      request a divide; sampled only in IDLE
//  dividend     in   WIDTH  numerator; captured on the accepted start edge
//  divisor      in   WIDTH  denominator; captured on the accepted start edge
//  busy         out  1      high from the accepted start edge until done drops
//  done         out  1      one-cycle strobe; results valid in that cycle
//  quotient     out  WIDTH  registered quotient; holds until the next accepted start
//  remainder    out  WIDTH  registered remainder; holds until the next accepted start
//  div_by_zero  out  1      registered; set with done when the captured divisor == 0
// BEHAVIOUR
//  Reset (async assert, any state): state=IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0.
//    The iteration counter and working registers are cleared.
//  FSM states: IDLE, RUN, DONE (encoding in package).
//  IDLE:
//    - start=0: stay in IDLE.
//    - start=1 and divisor!=0: latch operands, q_work=dividend, r_work=0, cnt=0; go to RUN.
//    - start=1 and divisor==0: quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1; go to DONE.
//  RUN: one iteration per edge.
//    - r_w = {r_work[WIDTH-1:0], q_work[WIDTH-1]} (WIDTH+1 bits); q_work <<= 1.
//    - trial = r_w - {1'b0, divisor_q} (WIDTH+1 bits).
//    - If trial MSB is 0: r_work = trial and q_work[0] = 1; otherwise r_work = r_w.
//    - cnt++. On the WIDTH-th iteration (cnt == WIDTH-1), load quotient/remainder from the
//      updated values, div_by_zero=0, and go to DONE.
//  DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally.
//    - start asserted during DONE is ignored; the requester must re-assert it in IDLE.
//  Latency: start edge E0 -> iterations on E1..E_WIDTH -> done high in the cycle after E_WIDTH.
//    - For WIDTH=8 that is 8 RUN cycles.
//    - Divide by zero: done is high in the cycle after E0.
//  busy = (state != IDLE). done = (state == DONE). Both are decoded from registered state only.
//  start while busy: ignored; operand inputs are don't-care outside IDLE.
//  Operands are sampled once; input changes during RUN do not affect the result.
//  Reset mid-RUN: aborts immediately; no done strobe; outputs clear to 0.
//  Arithmetic is unsigned only, with no overflow possible:
//    - quotient <= dividend.
//    - remainder < divisor when divisor != 0.
//  Invariant: dividend == quotient*divisor + remainder whenever div_by_zero==0.
// STRUCTURE
//  Package seq_divider_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_e;
//    localparam for the all-ones divide-by-zero quotient.
//  Sub-module div_step (combinational, parameterised WIDTH):
//    - in: r_work, q_work, divisor.
//    - out: next r_work, next q_work.
//    - Implements one restoring iteration, so the bench can check it standalone.
//  Top level: FSM, counter ($clog2(WIDTH) bits), operand/working registers, output registers.
// TESTING
//  1. 200 / 7 -> quotient=28, remainder=4, div_by_zero=0; done exactly 9 cycles after the start edge.
//  2. 255 / 1 -> 255 r 0.  5 / 9 -> 0 r 5.  0 / 3 -> 0 r 0.  255 / 255 -> 1 r 0.
//  3. 100 / 0 -> done in the next cycle; quotient=255, remainder=100, div_by_zero=1; busy high 1 cycle.
//  4. Start 200/7, then pulse start with 9/3 and change the operands during RUN.
//     -> The result is still 28 r 4 and only one done is seen.
//     Start held high through DONE -> the next divide begins only from IDLE.
//  5. Assert rst_n=0 on the 4th RUN cycle -> all outputs 0 immediately and no done.
//     Then 50/6 -> 8 r 2.
//  6. Random sweep, >=2000 pairs including divisor=0.
//     -> Check the invariant, remainder<divisor, and that outputs hold stable between dones.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Quotient reported on divide-by-zero; the top slices its low WIDTH bits (WIDTH <= 64).
  localparam logic [63:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, keep or restore.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r_work,
  input  logic [WIDTH-1:0] q_work,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] r_w;
  logic [WIDTH:0] trial;

  // r_work < divisor always holds, so both kept and restored remainders fit in WIDTH bits.
  always_comb begin
    r_w   = {r_work, q_work[WIDTH-1]};
    trial = r_w - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      r_next = trial[WIDTH-1:0];
      q_next = {q_work[WIDTH-2:0], 1'b1};
    end else begin
      r_next = r_w[WIDTH-1:0];
      q_next = {q_work[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned divider: one trial subtraction per clock, quotient/remainder with a done strobe.
//   state | meaning
//   IDLE  | waiting for start; results from the last divide are held
//   RUN   | WIDTH restoring iterations, one per clock
//   DONE  | one-cycle done strobe, then back to IDLE
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_e state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q_work;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] r_step;
  logic             last_iter;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_work (r_work),
    .q_work (q_work),
    .divisor(divisor_q),
    .r_next (r_step),
    .q_next (q_step)
  );

  assign last_iter = (cnt == LAST_ITER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      q_work      <= '0;
      r_work      <= '0;
      divisor_q   <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= DZ_QUOTIENT[WIDTH-1:0];
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              divisor_q <= divisor;
              q_work    <= dividend;
              r_work    <= '0;
              cnt       <= '0;
            end
          end
        end
        RUN: begin
          q_work <= q_step;
          r_work <= r_step;
          cnt    <= cnt + 1'b1;
          if (last_iter) begin
            quotient    <= q_step;
            remainder   <= r_step;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
